// File: rtl/jk_pkg.sv
// Shared J/K flip-flop excitation encodings and the current/desired-bit to {J,K} mapping.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Minimal {J,K} that moves a flop from cur to want.
  function automatic logic [1:0] jk_excite(input logic cur, input logic want);
    if (cur == want) begin
      return JK_HOLD;
    end
    return want ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single J/K flip-flop with synchronous active-high reset.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Loadable modulo-N up/down counter built from jk_ff cells; next state is pure
// per-bit J/K excitation, with a combinational terminal-count flag.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0][1:0] jk;
  logic                  lower_ones;
  logic                  lower_zeros;

  // Per-bit excitation: load > count (wrap or ripple-toggle) > hold.
  always_comb begin
    jk          = '0;
    lower_ones  = 1'b1;
    lower_zeros = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (load) begin
        jk[i] = {d[i], ~d[i]};
      end else if (en) begin
        if (up) begin
          if (q >= MAX_CNT) begin
            jk[i] = jk_excite(q[i], 1'b0);
          end else if (lower_ones) begin
            jk[i] = JK_TOGGLE;
          end
        end else begin
          if (q == '0) begin
            jk[i] = {MAX_CNT[i], ~MAX_CNT[i]};
          end else if (lower_zeros) begin
            jk[i] = JK_TOGGLE;
          end
        end
      end
      lower_ones  = lower_ones & q[i];
      lower_zeros = lower_zeros & ~q[i];
    end
  end

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (jk[gi][1]),
      .k   (jk[gi][0]),
      .q   (q[gi])
    );
  end

  // High on the cycle whose edge wraps, so it can carry into a cascaded stage.
  assign tc = en && (up ? (q == MAX_CNT) : (q == '0));

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parameterised synchronous modulo-N up/down counter built from `WIDTH` instances of the team's `jk_ff`. Next-state logic is expressed purely as J/K excitation per bit, not as an adder. The block is the consumer stage for `jk_ff`: it generates every J/K pair and collects every `q`. It provides a loadable decade/binary counter with a terminal-count flag for downstream dividers and timers.

## Interface
- `WIDTH`, 4, number of counter bits, which is also the number of `jk_ff` instances.
- `MODULUS`, 10, count range is 0 to MODULUS-1; legal values are 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset; clears the counter to 0.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `load` input 1: synchronous parallel load of `d`.
- `d` input WIDTH: load value.
- `q` output WIDTH: current count, taken directly from the `jk_ff` `q` pins.
- `tc` output 1: terminal count, combinational.
  - `up`=1: high when `en` && `q`==MODULUS-1.
  - `up`=0: high when `en` && `q`==0.

## Operation
- Priority on each rising edge: `rst` > `load` > `en` > hold.
- `rst`=1: every `jk_ff` receives `rst`=1 and `q` becomes 0. This holds regardless of `load`, `en` and `d`.
- `load`=1:
  - Each bit i gets J=d[i], K=~d[i], so `q`=d after the edge.
  - `d` ≥ MODULUS is loaded as-is; no clamping.
- `en`=1, `up`=1:
  - `q` < MODULUS-1: bit i toggles (J=K=1) iff bits 0..i-1 of `q` are all 1.
  - `q` ≥ MODULUS-1: wrap. Every bit set in `q` gets J=0, K=1; all others get J=K=0. Next `q` is 0.
- `en`=1, `up`=0:
  - `q` ≠ 0: bit i toggles iff bits 0..i-1 of `q` are all 0.
  - `q`==0: wrap. Bit i gets J=M[i], K=~M[i], where M = MODULUS-1.
- `en`=0 and `load`=0: all bits get J=K=0, so `q` holds.
- Out-of-range down count (`q` ≥ MODULUS): decrements normally until it re-enters range.
- Direction change (`up` toggled) takes effect on the next enabled edge; no extra cycle.
- MODULUS = 2^WIDTH: the up-wrap and down-wrap branches equal natural binary rollover.

## Timing
- Reset value: `q`=0. `tc`=0 while `en`=0.
- Latency from `rst`, `load` or `en` to `q` is 1 cycle; `q` is registered.
- `tc` is combinational from `q`, `en` and `up`. It is asserted during the cycle whose edge performs the wrap, so it is usable as a carry enable into a cascaded stage on the same edge.
- `load` and `en` in the same cycle: the load wins; no count occurs on that edge.
- `rst` asserted mid-count: `q`=0 on that edge. Counting resumes from 0 on the first edge with `rst`=0 and `en`=1.
- All J/K inputs must settle within one `clk` period; there are no multicycle paths.

## Structure
- Shared package `jk_pkg` holds:
  - Two-bit excitation constants `JK_HOLD`=00, `JK_RESET`=01, `JK_SET`=10, `JK_TOGGLE`=11, encoded as {J,K}.
  - A function mapping (current bit, desired bit) to the {J,K} pair.
- Sub-module: the existing `jk_ff`, instantiated `WIDTH` times in a generate loop. Per-bit `rst` is tied to the block `rst`.
- Excitation logic lives in a single `always_comb` in `jk_mod_counter`. No other sub-modules.

## Test plan
All scenarios use WIDTH=4 and MODULUS=10 unless stated.
- Reset: hold `rst`=1 for 2 cycles with `en`=1, `load`=1, `d`=7 → `q`=0 and `tc`=0 throughout.
- Up count: `en`=1, `up`=1 for 12 cycles from 0 → `q`=1,2,…,9,0,1,2. `tc`=1 only while `q`=9.
- Down count: `en`=1, `up`=0 from 0 → `q`=9,8,7. `tc`=1 only while `q`=0.
- Load versus enable: `load`=1, `en`=1, `d`=5 → `q`=5 next cycle. `load`=1, `d`=12, then `up`=1 → `q`=12, then 0 (wrap).
- Hold and mid-count reset: at `q`=6, `en`=0 for 3 cycles → `q` stays 6. Then `rst`=1 for 1 cycle with `en`=1 → `q`=0, then 1.
- Binary modulus: MODULUS=16. Up from 15 → 0; down from 0 → 15. `tc` pulses at 15 (up) and at 0 (down).
